// File: rtl/lsb_pkg.sv
// Shared definitions for the LSB front-panel poller: mode codes, read-word layout, FSM states.
// Latency: n/a (types, constants and a pure LED-update function).
// Backpressure: n/a.
package lsb_pkg;

  localparam logic [1:0] MODE_MIRROR = 2'b00;
  localparam logic [1:0] MODE_COUNT  = 2'b01;
  localparam logic [1:0] MODE_RUN    = 2'b10;
  localparam logic [1:0] MODE_READ   = 2'b11;

  // Bit positions inside the responder read word.
  localparam int BTN_LSB = 8;
  localparam int SWI_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_CALC = 2'd2,
    ST_WR   = 2'd3
  } state_e;

  // Next LED pattern from current pattern, freshly captured switches and press edges.
  function automatic logic [7:0] next_led(input logic [1:0] mode,
                                          input logic [7:0] led,
                                          input logic [3:0] btn,
                                          input logic [3:0] swi,
                                          input logic [3:0] pr);
    logic [7:0] v;
    v = led;
    case (mode)
      MODE_MIRROR: v = {btn, swi};
      MODE_COUNT: begin
        // clear beats inc, inc beats dec
        if (pr[2])      v = 8'h00;
        else if (pr[0]) v = led + 8'd1;
        else if (pr[1]) v = led - 8'd1;
      end
      MODE_RUN: begin
        if (led == 8'h00) v = 8'h01;
        else if (swi[0])  v = {led[0], led[7:1]};
        else              v = {led[6:0], led[7]};
      end
      default: v = led;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/lsb_poll_if.sv
// LSB responder bus: strobe/write-enable request, combinational-capable acknowledge.
// Latency: n/a (wires only).
// Backpressure: responder stalls the initiator by withholding ack while stb is high.
// Signals: stb, we, data_out (initiator -> responder); data_in, ack (responder -> initiator).
interface lsb_poll_if;
  logic        stb;
  logic        we;
  logic [7:0]  data_out;
  logic [31:0] data_in;
  logic        ack;

  modport master (output stb, output we, output data_out, input data_in, input ack);
  modport slave  (input stb, input we, input data_out, output data_in, output ack);
endinterface

// File: rtl/lsb_poll_tmr.sv
// Poll prescaler: free-running 0..POLL_CYCLES-1 counter whose wrap latches a pending request.
// Latency: poll_req rises one cycle after the counter sits at POLL_CYCLES-1.
// Backpressure: request is held until clear; extra wraps while pending merge into one.
// Ports: clk, rst (sync, active-high), clear (consume request), poll_req (pending flag).
module lsb_poll_tmr #(
  parameter int POLL_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic poll_req
);
  localparam int CW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;

  logic [CW-1:0] cnt;
  logic          pend;
  logic          wrap;

  assign wrap     = (cnt == CW'(POLL_CYCLES - 1));
  assign poll_req = pend;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      pend <= 1'b0;
    end else begin
      cnt  <= wrap ? '0 : cnt + 1'b1;
      // a wrap in the same cycle as the consume must not be lost
      pend <= wrap | (pend & ~clear);
    end
  end
endmodule

// File: rtl/lsb_poll.sv
// Front-panel poller: periodically reads buttons/switches, derives press edges and writes LEDs back.
// Latency: read beat >=1 cycle, one CALC cycle, write beat >=1 cycle; bus beats abort after TIMEOUT.
// Backpressure: stb/we/data_out held while ack is low; wait is bounded, aborts pulse err.
// Ports: clk, rst, en, mode, bus (master), btn, swi, press, led_val, busy, err.
module lsb_poll
  import lsb_pkg::*;
#(
  parameter int POLL_CYCLES = 100000,
  parameter int TIMEOUT     = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        mode,
  lsb_poll_if.master        bus,
  output logic [3:0]        btn,
  output logic [3:0]        swi,
  output logic [3:0]        press,
  output logic [7:0]        led_val,
  output logic              busy,
  output logic              err
);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  state_e        state;
  logic          stb_q;
  logic          we_q;
  logic [7:0]    dout_q;
  logic [3:0]    old_btn;
  logic [WW-1:0] wait_cnt;
  logic          poll_req;
  logic [3:0]    pr;
  logic [7:0]    led_nxt;
  logic          unused_bits;

  assign bus.stb      = stb_q;
  assign bus.we       = we_q;
  assign bus.data_out = dout_q;
  assign busy         = (state != ST_IDLE);
  assign unused_bits  = ^{bus.data_in[31:12], bus.data_in[7:4]};

  // IDLE always consumes the pending request; with en=0 it is simply dropped.
  lsb_poll_tmr #(.POLL_CYCLES(POLL_CYCLES)) u_tmr (
    .clk      (clk),
    .rst      (rst),
    .clear    (state == ST_IDLE),
    .poll_req (poll_req)
  );

  assign pr      = btn & ~old_btn;
  assign led_nxt = next_led(mode, led_val, btn, swi, pr);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      stb_q    <= 1'b0;
      we_q     <= 1'b0;
      dout_q   <= 8'h00;
      btn      <= 4'h0;
      swi      <= 4'h0;
      old_btn  <= 4'h0;
      press    <= 4'h0;
      led_val  <= 8'h00;
      err      <= 1'b0;
      wait_cnt <= '0;
    end else begin
      press <= 4'h0;
      err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (poll_req && en) begin
            state    <= ST_RD;
            stb_q    <= 1'b1;
            we_q     <= 1'b0;
            wait_cnt <= '0;
          end
        end
        ST_RD: begin
          if (bus.ack) begin
            old_btn <= btn;
            btn     <= bus.data_in[BTN_LSB +: 4];
            swi     <= bus.data_in[SWI_LSB +: 4];
            stb_q   <= 1'b0;
            state   <= ST_CALC;
          end else if (wait_cnt == WAIT_LAST) begin
            stb_q <= 1'b0;
            err   <= 1'b1;
            state <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_CALC: begin
          press   <= pr;
          led_val <= led_nxt;
          if (mode != MODE_READ) begin
            state    <= ST_WR;
            stb_q    <= 1'b1;
            we_q     <= 1'b1;
            dout_q   <= led_nxt;
            wait_cnt <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_WR: begin
          if (bus.ack || wait_cnt == WAIT_LAST) begin
            stb_q  <= 1'b0;
            we_q   <= 1'b0;
            dout_q <= 8'h00;
            err    <= ~bus.ack;
            state  <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsb_poll.sv
// Bench for lsb_poll: model responder plus scoreboard of expected bus beats, press pulses and errors.
// Latency: n/a.
// Backpressure: responder can delay or withhold ack.
module tb_lsb_poll;
  localparam int K_RD  = 0;
  localparam int K_WR  = 1;
  localparam int K_ERR = 2;

  typedef struct {
    int         kind;
    logic [7:0] dat;
    int         len;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [3:0] tb_btn, tb_swi;
  logic [3:0] btn, swi, press;
  logic [7:0] led_val;
  logic       busy, err;

  int  checks = 0;
  int  errors = 0;
  int  ack_dly = 0;
  bit  ack_never = 1'b0;
  int  stb_cyc = 0;

  exp_t       exp_q[$];
  logic [3:0] press_q[$];

  always #5 clk = ~clk;

  lsb_poll_if bus ();

  assign bus.data_in = {20'd0, tb_btn, 4'd0, tb_swi};
  assign bus.ack     = bus.stb && !ack_never && (stb_cyc >= ack_dly);

  always @(posedge clk) begin
    if (bus.stb && !bus.ack) stb_cyc <= stb_cyc + 1;
    else                     stb_cyc <= 0;
  end

  lsb_poll #(.POLL_CYCLES(8), .TIMEOUT(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .mode    (mode),
    .bus     (bus.master),
    .btn     (btn),
    .swi     (swi),
    .press   (press),
    .led_val (led_val),
    .busy    (busy),
    .err     (err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // ---------------- monitor ----------------
  int         stb_len = 0;
  logic [7:0] d0;
  logic       we0;
  bit         unstable;
  exp_t       e;
  logic [3:0] pe;

  always @(negedge clk) begin
    if (err) begin
      if (exp_q.size() == 0) chk("unexpected_err", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("err_kind", e.kind, K_ERR);
        chk("err_len", stb_len, e.len);
      end
      stb_len = 0;
    end
    if (bus.stb) begin
      if (stb_len == 0) begin
        d0 = bus.data_out; we0 = bus.we; unstable = 1'b0;
      end else if (bus.data_out !== d0 || bus.we !== we0) begin
        unstable = 1'b1;
      end
      stb_len++;
      if (bus.ack) begin
        if (exp_q.size() == 0) chk("unexpected_beat", {bus.we, bus.data_out}, 0);
        else begin
          e = exp_q.pop_front();
          chk("beat_kind", bus.we ? K_WR : K_RD, e.kind);
          if (bus.we) chk("wr_data", bus.data_out, e.dat);
          chk("beat_len", stb_len, e.len);
          chk("beat_stable", unstable, 0);
        end
        stb_len = 0;
      end
    end else begin
      stb_len = 0;
      chk("idle_bus", {bus.we, bus.data_out}, 0);
    end
    if (press != 4'h0) begin
      if (press_q.size() == 0) chk("unexpected_press", press, 0);
      else begin
        pe = press_q.pop_front();
        chk("press", press, pe);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic push(input int kind, input logic [7:0] dat, input int len);
    exp_t x;
    x.kind = kind; x.dat = dat; x.len = len;
    exp_q.push_back(x);
  endtask

  task automatic wait_poll();
    int n;
    n = 0;
    while (!busy && n < 40) begin @(negedge clk); n++; end
    if (!busy) begin checks++; errors++; $display("FAIL poll_start: busy 0 expected 1 within 40 cycles"); end
    n = 0;
    while (busy && n < 40) begin @(negedge clk); n++; end
    if (busy) begin checks++; errors++; $display("FAIL poll_end: busy 1 expected 0 within 40 cycles"); end
  endtask

  task automatic poll(input logic [1:0] m, input logic [3:0] b, input logic [3:0] s,
                      input bit wr, input logic [7:0] led_exp, input logic [3:0] pr_exp,
                      input int len);
    mode = m; tb_btn = b; tb_swi = s;
    push(K_RD, 8'h00, len);
    if (pr_exp != 4'h0) press_q.push_back(pr_exp);
    if (wr) push(K_WR, led_exp, len);
    wait_poll();
    chk("led_val", led_val, led_exp);
    chk("btn", btn, b);
    chk("swi", swi, s);
    chk("busy_after", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; en = 1'b1; mode = 2'b00; tb_btn = 4'b0101; tb_swi = 4'b0011;
    repeat (3) @(negedge clk);
    chk("rst_out", {bus.stb, bus.we, bus.data_out, btn, swi, press, led_val, busy, err}, 0);
    rst = 1'b0;

    // mirror
    poll(2'b00, 4'b0101, 4'b0011, 1, 8'h53, 4'b0101, 1);
    poll(2'b00, 4'hF, 4'hF, 1, 8'hFF, 4'b1010, 1);
    // counter
    poll(2'b01, 4'hE, 4'hF, 1, 8'hFF, 4'b0000, 1);
    poll(2'b01, 4'hF, 4'hF, 1, 8'h00, 4'b0001, 1);
    poll(2'b01, 4'hF, 4'hF, 1, 8'h00, 4'b0000, 1);
    poll(2'b01, 4'hA, 4'hF, 1, 8'h00, 4'b0000, 1);
    poll(2'b01, 4'hB, 4'hF, 1, 8'h01, 4'b0001, 1);
    poll(2'b01, 4'hF, 4'hF, 1, 8'h00, 4'b0100, 1);
    poll(2'b01, 4'hD, 4'hF, 1, 8'h00, 4'b0000, 1);
    poll(2'b01, 4'hF, 4'hF, 1, 8'hFF, 4'b0010, 1);
    poll(2'b01, 4'hC, 4'hF, 1, 8'hFF, 4'b0000, 1);
    poll(2'b01, 4'hF, 4'hF, 1, 8'h00, 4'b0011, 1);
    // running light
    poll(2'b10, 4'hF, 4'hE, 1, 8'h01, 4'b0000, 1);
    poll(2'b10, 4'hF, 4'hE, 1, 8'h02, 4'b0000, 1);
    poll(2'b10, 4'hF, 4'hE, 1, 8'h04, 4'b0000, 1);
    poll(2'b10, 4'hF, 4'hF, 1, 8'h02, 4'b0000, 1);
    poll(2'b10, 4'hF, 4'hF, 1, 8'h01, 4'b0000, 1);
    poll(2'b10, 4'hF, 4'hF, 1, 8'h80, 4'b0000, 1);
    // read-only
    poll(2'b11, 4'h0, 4'h0, 0, 8'h80, 4'b0000, 1);
    poll(2'b11, 4'h5, 4'hA, 0, 8'h80, 4'b0101, 1);
    // delayed ack
    ack_dly = 2;
    poll(2'b00, 4'h5, 4'hA, 1, 8'h5A, 4'b0000, 3);
    // withheld ack: read aborts, nothing captured
    ack_never = 1'b1;
    tb_btn = 4'hF; tb_swi = 4'hF;
    push(K_ERR, 8'h00, 4);
    wait_poll();
    chk("to_led", led_val, 8'h5A);
    chk("to_btn", btn, 4'h5);
    chk("to_swi", swi, 4'hA);
    ack_never = 1'b0;

    // reset during a write beat
    tb_btn = 4'h5; tb_swi = 4'hA; mode = 2'b00;
    push(K_RD, 8'h00, 3);
    n = 0;
    while (!(bus.stb && bus.we) && n < 60) begin @(negedge clk); n++; end
    chk("wr_seen", bus.stb & bus.we, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid", {bus.stb, bus.we, bus.data_out, btn, swi, press, led_val, busy, err}, 0);
    rst = 1'b0;
    ack_dly = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rst_quiet", busy, 0);
    end
    poll(2'b00, 4'h5, 4'hA, 1, 8'h5A, 4'b0101, 1);

    repeat (4) @(negedge clk);
    chk("exp_q_empty", exp_q.size(), 0);
    chk("press_q_empty", press_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
